// File: rtl/mips_alu.sv
// mips_alu -- 32-bit execute-stage ALU for the MIPS datapath.
//
// Performs ADD, SUB, AND and OR on two operands. Operands and the operation
// select are captured on the rising clock edge. Result, zero flag and
// out_valid appear one cycle later. The zero flag feeds branch resolution.
//
// Optional feature macro: ALU_OVF_EN
//   When defined, adds the registered signed-overflow output ovf.
//   When undefined, the ovf port and its logic are absent.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low (priority over in_valid)
//   in_valid   a/b/control are valid this cycle
//   a, b       WIDTH-bit operands
//   control    00 ADD, 01 SUB, 10 AND, 11 OR
//   result     registered result (holds when in_valid = 0)
//   zflag      registered, 1 when result is all zeros
//   out_valid  result/zflag were updated by the previous edge
//   ovf        registered signed overflow (ALU_OVF_EN only)
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] result,
  output logic             zflag,
  output logic             out_valid
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Carry out of ADD/SUB is dropped: the result is modulo 2^WIDTH.
  function automatic logic signed [WIDTH-1:0] alu_op(
    input logic signed [WIDTH-1:0] op_a,
    input logic signed [WIDTH-1:0] op_b,
    input logic [1:0]              op
  );
    logic signed [WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = op_a + op_b;
      OP_SUB:  r = op_a - op_b;
      OP_AND:  r = op_a & op_b;
      default: r = op_a | op_b;
    endcase
    return r;
  endfunction

`ifdef ALU_OVF_EN
  // Signed overflow from operand and result sign bits. SUB overflows when
  // the operands differ in sign and the result sign disagrees with a.
  function automatic logic ovf_calc(
    input logic signed [WIDTH-1:0] op_a,
    input logic signed [WIDTH-1:0] op_b,
    input logic signed [WIDTH-1:0] r,
    input logic [1:0]              op
  );
    logic o;
    case (op)
      OP_ADD:  o = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (r[WIDTH-1] != op_a[WIDTH-1]);
      OP_SUB:  o = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (r[WIDTH-1] != op_a[WIDTH-1]);
      default: o = 1'b0;
    endcase
    return o;
  endfunction
`endif

  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic signed [WIDTH-1:0] res_p0;

  logic signed [WIDTH-1:0] res_p1_d, res_p1_q;
  logic                    zf_p1_d,  zf_p1_q;
  logic                    vld_p1_d, vld_p1_q;
`ifdef ALU_OVF_EN
  logic                    ovf_p1_d, ovf_p1_q;
`endif

  assign a_p0   = a;
  assign b_p0   = b;
  assign res_p0 = alu_op(a_p0, b_p0, control);

  always_comb begin
    res_p1_d = res_p1_q;
    zf_p1_d  = zf_p1_q;
    vld_p1_d = 1'b0;
`ifdef ALU_OVF_EN
    ovf_p1_d = ovf_p1_q;
`endif
    if (in_valid) begin
      res_p1_d = res_p0;
      zf_p1_d  = (res_p0 == '0);
      vld_p1_d = 1'b1;
`ifdef ALU_OVF_EN
      ovf_p1_d = ovf_calc(a_p0, b_p0, res_p0, control);
`endif
    end
  end

  // Stage p0 -> p1: single register stage, reset also clears the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_p1_q <= '0;
      zf_p1_q  <= 1'b0;
      vld_p1_q <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_p1_q <= 1'b0;
`endif
    end else begin
      res_p1_q <= res_p1_d;
      zf_p1_q  <= zf_p1_d;
      vld_p1_q <= vld_p1_d;
`ifdef ALU_OVF_EN
      ovf_p1_q <= ovf_p1_d;
`endif
    end
  end

  assign result    = res_p1_q;
  assign zflag     = zf_p1_q;
  assign out_valid = vld_p1_q;
`ifdef ALU_OVF_EN
  assign ovf       = ovf_p1_q;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Testbench for mips_alu: directed cases followed by randomized traffic,
// checked against a behavioural model of the ALU.
module tb_mips_alu;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       control;
  logic [WIDTH-1:0] result;
  logic             zflag;
  logic             out_valid;
`ifdef ALU_OVF_EN
  logic             ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [WIDTH-1:0] exp_res = '0;
  logic             exp_z   = 1'b0;
  logic             exp_v   = 1'b0;
  logic             exp_o   = 1'b0;

  mips_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .control   (control),
    .result    (result),
    .zflag     (zflag),
    .out_valid (out_valid)
`ifdef ALU_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference result from the operation's arithmetic meaning, using wide
  // integers and an explicit modulo-2^WIDTH reduction.
  function automatic longint model_res(input longint va, input longint vb, input int op);
    longint m;
    m = (longint'(1) << WIDTH);
    case (op)
      0:       return (va + vb) % m;
      1:       return (va - vb + m) % m;
      2:       return va & vb;
      default: return va | vb;
    endcase
  endfunction

  // Overflow: the exact signed sum/difference falls outside the WIDTH range.
  function automatic logic model_ovf(input longint va, input longint vb, input int op);
    longint sa, sb, ex, lo, hi;
    sa = (va >= (longint'(1) << (WIDTH-1))) ? va - (longint'(1) << WIDTH) : va;
    sb = (vb >= (longint'(1) << (WIDTH-1))) ? vb - (longint'(1) << WIDTH) : vb;
    hi = (longint'(1) << (WIDTH-1)) - 1;
    lo = -(longint'(1) << (WIDTH-1));
    if (op == 0)      ex = sa + sb;
    else if (op == 1) ex = sa - sb;
    else              return 1'b0;
    return (ex > hi) || (ex < lo);
  endfunction

  // Apply one cycle of inputs, advance past the edge, update the model, compare.
  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] va,
                      input logic [WIDTH-1:0] vb, input logic [1:0] op, input string tag);
    rst_n    = r;
    in_valid = v;
    a        = va;
    b        = vb;
    control  = op;
    @(posedge clk);
    #1;
    if (!r) begin
      exp_res = '0; exp_z = 1'b0; exp_v = 1'b0; exp_o = 1'b0;
    end else if (v) begin
      exp_res = WIDTH'(model_res(longint'(va), longint'(vb), int'(op)));
      exp_z   = (exp_res == 0);
      exp_v   = 1'b1;
      exp_o   = model_ovf(longint'(va), longint'(vb), int'(op));
    end else begin
      exp_v   = 1'b0;
    end
    check({tag, ".result"},    64'(result),    64'(exp_res));
    check({tag, ".zflag"},     64'(zflag),     64'(exp_z));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_v));
`ifdef ALU_OVF_EN
    check({tag, ".ovf"},       64'(ovf),       64'(exp_o));
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; control = 2'b00;

    step(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, "reset0");
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, "reset1");

    step(1'b1, 1'b1, 32'h1, 32'h1, 2'b00, "add_1_1");
    step(1'b1, 1'b0, 32'h9, 32'h7, 2'b01, "hold");
    step(1'b1, 1'b1, 32'h1, 32'h1, 2'b01, "sub_zero");
    step(1'b1, 1'b1, 32'h0, 32'h1, 2'b01, "sub_neg1");
    step(1'b1, 1'b1, 32'h1, 32'h3, 2'b10, "and_1_3");
    step(1'b1, 1'b1, 32'h3, 32'h1, 2'b11, "or_3_1");
    step(1'b1, 1'b1, 32'h1, 32'h1, 2'b11, "or_1_1");
    step(1'b1, 1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 2'b10, "and_zero");
    step(1'b1, 1'b1, 32'h7FFFFFFF, 32'h1, 2'b00, "add_ovf");
    step(1'b1, 1'b1, 32'h80000000, 32'h1, 2'b01, "sub_ovf");
    step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h1, 2'b00, "add_wrap");
    step(1'b1, 1'b0, 32'h5, 32'h5, 2'b00, "hold_ovf");
    step(1'b0, 1'b1, 32'h5, 32'h5, 2'b00, "rst_prio");

    step(1'b1, 1'b1, 32'h5, 32'h3, 2'b00, "b2b_add");
    step(1'b1, 1'b1, 32'h5, 32'h3, 2'b01, "b2b_sub");
    step(1'b1, 1'b1, 32'h5, 32'h3, 2'b10, "b2b_and");
    step(1'b1, 1'b1, 32'h5, 32'h3, 2'b11, "b2b_or");

    for (int i = 0; i < 400; i++) begin
      logic             rr, vv;
      logic [WIDTH-1:0] ra, rb;
      logic [1:0]       rc;
      rr = ($urandom_range(0, 19) != 0);
      vv = ($urandom_range(0, 3) != 0);
      rc = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       begin ra = $urandom; rb = ra; end
        1:       begin ra = 32'h7FFFFFFF ^ 32'($urandom_range(0, 3)); rb = 32'($urandom_range(0, 3)); end
        2:       begin ra = 32'h80000000; rb = $urandom; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      step(rr, vv, ra, rb, rc, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
